// File: rtl/fifo_ram.sv
// fifo_ram: D x W two-port storage array for the synchronous FIFO.
//   clk    : write clock (rising edge)
//   we     : write enable; din is stored at wraddr on the rising edge
//   wraddr : write address
//   rdaddr : read address
//   din    : write data
//   dout   : combinational read data, mem[rdaddr], zero-cycle latency
// Contents are intentionally not reset.
module fifo_ram #(
    parameter int unsigned W  = 8,
    parameter int unsigned D  = 4,
    localparam int unsigned AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wraddr,
    input  logic [AW-1:0] rdaddr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);

    logic [W-1:0] mem_q [D];

    // Clocked write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wraddr] <= din;
        end
    end

    // Combinational read port.
    assign dout = mem_q[rdaddr];

endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock first-word-fall-through FIFO.
//   clk   : clock, all state updates on rising edge
//   rst   : synchronous active-high reset (pointers and pulses only)
//   push  : write request; din captured when accepted
//   din   : write data
//   pop   : read request; head word discarded when accepted
//   dout  : head word, valid while empty=0
//   empty : count == 0
//   full  : count == D
//   count : stored words, 0..D
//   ovf   : one-cycle pulse after a rejected push
//   unf   : one-cycle pulse after a rejected pop
module fifo_sync #(
    parameter int unsigned W  = 8,
    parameter int unsigned D  = 4,
    localparam int unsigned DW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [DW:0]   count,
    output logic          ovf,
    output logic          unf
);

    localparam int unsigned PW = DW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push_ok;
    logic          pop_ok;

    // Flags decoded from the pointer registers.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[DW-1:0] == rd_q[DW-1:0]) && (wr_q[DW] != rd_q[DW]);
    assign count = wr_q - rd_q;

    // Acceptance, pointer advance and error pulses.
    always_comb begin
        push_ok = 1'b0;
        pop_ok  = 1'b0;
        wr_d    = wr_q;
        rd_d    = rd_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;

        // A simultaneous pop frees the slot, so a push into a full FIFO is
        // still accepted in that case.
        push_ok = push && (!full || pop);
        pop_ok  = pop && !empty;

        if (push_ok) begin
            wr_d = wr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + PW'(1);
        end

        ovf_d = push && full && !pop;
        unf_d = pop && empty;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;

    // Reset blocks RAM writes so a push during reset leaves storage untouched.
    fifo_ram #(
        .W (W),
        .D (D)
    ) u_ram (
        .clk    (clk),
        .we     (push_ok && !rst),
        .wraddr (wr_q[DW-1:0]),
        .rdaddr (rd_q[DW-1:0]),
        .din    (din),
        .dout   (dout)
    );

endmodule

// File: tb/tb_fifo_sync.sv
module tb_fifo_sync;

    logic       clk;
    logic       rst;
    logic       push;
    logic [7:0] din;
    logic       pop;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       ovf;
    logic       unf;

    int total;
    int bad;

    fifo_sync #(
        .W (8),
        .D (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .count (count),
        .ovf   (ovf),
        .unf   (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs after the falling edge, take one rising edge, sample 1 time unit later.
    task automatic cyc(input logic p, input logic q, input logic [7:0] d, input logic r = 1'b0);
        @(negedge clk);
        push = p;
        pop  = q;
        din  = d;
        rst  = r;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        rst  = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        din   = 8'h00;

        // Reset with a concurrent push: reset wins.
        cyc(1'b1, 1'b0, 8'hEE, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);

        // Fill with 11,22,33,44.
        cyc(1'b1, 1'b0, 8'h11);
        chk("fill1_count", count, 1);
        chk("fill1_empty", empty, 0);
        chk("fill1_dout", dout, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        chk("fill2_count", count, 2);
        chk("fill2_dout", dout, 8'h11);
        cyc(1'b1, 1'b0, 8'h33);
        chk("fill3_count", count, 3);
        chk("fill3_full", full, 0);
        chk("fill3_dout", dout, 8'h11);
        cyc(1'b1, 1'b0, 8'h44);
        chk("fill4_count", count, 4);
        chk("fill4_full", full, 1);
        chk("fill4_dout", dout, 8'h11);

        // Overflow: push while full without pop.
        cyc(1'b1, 1'b0, 8'h55);
        chk("ovf_pulse", ovf, 1);
        chk("ovf_count", count, 4);
        chk("ovf_dout", dout, 8'h11);
        cyc(1'b0, 1'b0, 8'h00);
        chk("ovf_clear", ovf, 0);

        // Drain: 11,22,33,44 in order, 55 never stored.
        chk("drain_h0", dout, 8'h11);
        cyc(1'b0, 1'b1, 8'h00);
        chk("drain_h1", dout, 8'h22);
        chk("drain_c1", count, 3);
        cyc(1'b0, 1'b1, 8'h00);
        chk("drain_h2", dout, 8'h33);
        cyc(1'b0, 1'b1, 8'h00);
        chk("drain_h3", dout, 8'h44);
        chk("drain_c3", count, 1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);
        chk("drain_unf", unf, 0);

        // Underflow: pop while empty.
        cyc(1'b0, 1'b1, 8'h00);
        chk("unf_pulse", unf, 1);
        chk("unf_count", count, 0);
        chk("unf_empty", empty, 1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("unf_clear", unf, 0);

        // Push+pop while empty: push taken, pop rejected.
        cyc(1'b1, 1'b1, 8'hA5);
        chk("pp_empty_count", count, 1);
        chk("pp_empty_dout", dout, 8'hA5);
        chk("pp_empty_unf", unf, 1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("pp_empty_pop", empty, 1);
        chk("pp_empty_unf2", unf, 0);

        // Push+pop while full.
        cyc(1'b1, 1'b0, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        cyc(1'b1, 1'b0, 8'h33);
        cyc(1'b1, 1'b0, 8'h44);
        chk("ppf_pre_full", full, 1);
        cyc(1'b1, 1'b1, 8'h66);
        chk("ppf_count", count, 4);
        chk("ppf_full", full, 1);
        chk("ppf_ovf", ovf, 0);
        chk("ppf_dout", dout, 8'h22);
        cyc(1'b0, 1'b1, 8'h00);
        chk("ppf_h33", dout, 8'h33);
        cyc(1'b0, 1'b1, 8'h00);
        chk("ppf_h44", dout, 8'h44);
        cyc(1'b0, 1'b1, 8'h00);
        chk("ppf_h66", dout, 8'h66);
        cyc(1'b0, 1'b1, 8'h00);
        chk("ppf_empty", empty, 1);

        // Three fill/drain rounds wrap both pointers more than twice.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                v = 8'(8'h30 + 8'(r * 16) + 8'(i));
                cyc(1'b1, 1'b0, v);
            end
            chk($sformatf("wrap%0d_full", r), full, 1);
            chk($sformatf("wrap%0d_count", r), count, 4);
            for (int i = 0; i < 4; i++) begin
                v = 8'(8'h30 + 8'(r * 16) + 8'(i));
                chk($sformatf("wrap%0d_d%0d", r, i), dout, v);
                cyc(1'b0, 1'b1, 8'h00);
            end
            chk($sformatf("wrap%0d_empty", r), empty, 1);
            chk($sformatf("wrap%0d_nfull", r), full, 0);
        end

        // Reset mid-operation with three words stored and push asserted.
        cyc(1'b1, 1'b0, 8'hC1);
        cyc(1'b1, 1'b0, 8'hC2);
        cyc(1'b1, 1'b0, 8'hC3);
        chk("mid_pre_count", count, 3);
        cyc(1'b1, 1'b0, 8'h99, 1'b1);
        chk("mid_count", count, 0);
        chk("mid_empty", empty, 1);
        chk("mid_full", full, 0);
        chk("mid_ovf", ovf, 0);
        cyc(1'b1, 1'b0, 8'h77);
        chk("post_rst_dout", dout, 8'h77);
        chk("post_rst_count", count, 1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("post_rst_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
